vram1_high_fetch_arb: RTL

- Access sequencer and arbiter directly upstream of the 4k x 8 VRAM1 high-byte SRAM.
- Time-multiplexes the single SRAM port between two users:
  - the video scan path, which fetches one tilemap byte per 8-pixel character;
  - the CPU bus, which performs byte reads and writes.
- Drives SRAM address, data, WR_n and RD_n, and captures the SRAM's registered read data.
- Video has strict priority. CPU accesses fill the remaining MCLK cycles.

---
 rtl/vram1_fetch_pkg.sv | 22 ++
 rtl/vram1_scan_addr.sv | 31 +++
 rtl/vram1_high_fetch_arb.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vram1_fetch_pkg.sv
// Shared types and constants for the VRAM1 high-byte fetch arbiter.
package vram1_fetch_pkg;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned MAP_COLS = 64;
    localparam int unsigned COL_W    = $clog2(MAP_COLS);
    localparam int unsigned ROW_W    = ADDR_W - COL_W;

    localparam logic [2:0] VID_PHASE_DEF = 3'd0;
    localparam logic [8:0] LOOKAHEAD_DEF = 9'd8;

    typedef enum logic [2:0] {
        StIdle,
        StVrd,
        StVcap,
        StCwr,
        StCrd,
        StCcap
    } state_t;

endpackage

// File: rtl/vram1_scan_addr.sv
// Tilemap address from scan position: scroll add, divide by 8, pack {row, col}.
// Scroll inputs are only used when VRAM1_FETCH_SCROLL_EN is defined.
module vram1_scan_addr
    import vram1_fetch_pkg::*;
#(
    parameter logic [8:0] LOOKAHEAD = LOOKAHEAD_DEF
) (
    input  logic [8:0]        hcnt,
    input  logic [8:0]        vcnt,
    input  logic [8:0]        scrx,
    input  logic [8:0]        scry,
    output logic [ADDR_W-1:0] addr
);

    logic [8:0] hsum;
    logic [8:0] vsum;

`ifdef VRAM1_FETCH_SCROLL_EN
    assign hsum = hcnt + scrx + LOOKAHEAD;
    assign vsum = vcnt + scry;
`else
    logic unused_scroll;
    assign unused_scroll = ^{scrx, scry};
    assign hsum = hcnt + LOOKAHEAD;
    assign vsum = vcnt;
`endif

    // 9-bit sums wrap mod 512; the top bits are the character row/column.
    assign addr = {vsum[8 -: ROW_W], hsum[8 -: COL_W]};

endmodule

// File: rtl/vram1_high_fetch_arb.sv
// Time-multiplexes the VRAM1 high-byte SRAM between video tile fetches (strict priority) and
// CPU byte accesses. Scroll support is enabled by defining VRAM1_FETCH_SCROLL_EN.
module vram1_high_fetch_arb
    import vram1_fetch_pkg::*;
#(
    parameter logic [2:0] VID_PHASE = VID_PHASE_DEF,
    parameter logic [8:0] LOOKAHEAD = LOOKAHEAD_DEF
) (
    input  logic              i_MCLK,
    input  logic              i_RST,
    input  logic              i_PXCEN,
    input  logic              i_HLOAD,
    input  logic              i_VBLANK,
    input  logic [8:0]        i_HCNT,
    input  logic [8:0]        i_VCNT,
    input  logic [8:0]        i_SCRX,
    input  logic [8:0]        i_SCRY,
    input  logic              i_CPU_REQ,
    input  logic              i_CPU_WR,
    input  logic [ADDR_W-1:0] i_CPU_ADDR,
    input  logic [DATA_W-1:0] i_CPU_DIN,
    output logic              o_CPU_ACK,
    output logic [DATA_W-1:0] o_CPU_DOUT,
    output logic [ADDR_W-1:0] o_ADDR,
    output logic [DATA_W-1:0] o_DOUT,
    output logic              o_WR_n,
    output logic              o_RD_n,
    input  logic [DATA_W-1:0] i_DIN,
    output logic [DATA_W-1:0] o_TILE_DATA,
    output logic              o_TILE_VALID
);

    state_t            state_q, state_d;
    logic [2:0]        phase_q, phase_d;
    logic              v_pend_q, v_pend_d;
    logic [ADDR_W-1:0] vaddr_q, vaddr_d, scan_addr;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
    logic [DATA_W-1:0] tile_data_q, tile_data_d;
    logic              wr_n_q, wr_n_d, rd_n_q, rd_n_d;
    logic              ack_q, ack_d, tile_valid_q, tile_valid_d;
    logic              trig;

    vram1_scan_addr #(
        .LOOKAHEAD(LOOKAHEAD)
    ) u_scan_addr (
        .hcnt(i_HCNT),
        .vcnt(i_VCNT),
        .scrx(i_SCRX),
        .scry(i_SCRY),
        .addr(scan_addr)
    );

    assign trig = i_PXCEN && (phase_q == VID_PHASE) && !i_VBLANK;

    always_comb begin
        phase_d = phase_q;
        if (i_HLOAD) begin
            phase_d = 3'd0;
        end else if (i_PXCEN) begin
            phase_d = phase_q + 3'd1;
        end
    end

    // Strobes and addresses are registered so they line up with the state they belong to.
    always_comb begin
        state_d      = state_q;
        v_pend_d     = v_pend_q;
        vaddr_d      = trig ? scan_addr : vaddr_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        cpu_dout_d   = cpu_dout_q;
        tile_data_d  = tile_data_q;
        wr_n_d       = 1'b1;
        rd_n_d       = 1'b1;
        ack_d        = 1'b0;
        tile_valid_d = 1'b0;

        if (trig && (state_q != StIdle)) begin
            v_pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (trig || v_pend_q) begin
                    state_d  = StVrd;
                    v_pend_d = 1'b0;
                    addr_d   = vaddr_d;
                    rd_n_d   = 1'b0;
                end else if (i_CPU_REQ && !ack_q) begin
                    addr_d = i_CPU_ADDR;
                    if (i_CPU_WR) begin
                        state_d = StCwr;
                        dout_d  = i_CPU_DIN;
                        wr_n_d  = 1'b0;
                    end else begin
                        state_d = StCrd;
                        rd_n_d  = 1'b0;
                    end
                end
            end
            StVrd:  state_d = StVcap;
            StVcap: begin
                state_d      = StIdle;
                tile_data_d  = i_DIN;
                tile_valid_d = 1'b1;
            end
            StCwr: begin
                state_d = StIdle;
                ack_d   = 1'b1;
            end
            StCrd:  state_d = StCcap;
            StCcap: begin
                state_d    = StIdle;
                cpu_dout_d = i_DIN;
                ack_d      = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            state_q      <= StIdle;
            phase_q      <= 3'd0;
            v_pend_q     <= 1'b0;
            vaddr_q      <= '0;
            addr_q       <= '0;
            dout_q       <= '0;
            cpu_dout_q   <= '0;
            tile_data_q  <= '0;
            wr_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
            ack_q        <= 1'b0;
            tile_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            v_pend_q     <= v_pend_d;
            vaddr_q      <= vaddr_d;
            addr_q       <= addr_d;
            dout_q       <= dout_d;
            cpu_dout_q   <= cpu_dout_d;
            tile_data_q  <= tile_data_d;
            wr_n_q       <= wr_n_d;
            rd_n_q       <= rd_n_d;
            ack_q        <= ack_d;
            tile_valid_q <= tile_valid_d;
        end
    end

    assign o_ADDR       = addr_q;
    assign o_DOUT       = dout_q;
    assign o_WR_n       = wr_n_q;
    assign o_RD_n       = rd_n_q;
    assign o_CPU_ACK    = ack_q;
    assign o_CPU_DOUT   = cpu_dout_q;
    assign o_TILE_DATA  = tile_data_q;
    assign o_TILE_VALID = tile_valid_q;

endmodule
